// File: rtl/regfile_reader.sv
// Register-file dump sequencer: walks every entry once per start request and
// streams (index, data) over a valid/ready handshake, optionally dropping zeros.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rd_addr presented, capture (or skip) rd_data at the next edge
// HOLD  | entry held on out_* until the consumer accepts it
// DONE  | one-cycle completion pulse
module regfile_reader #(
  parameter int NUM_REGS  = 32,
  parameter int WIDTH     = 32,
  parameter int SKIP_ZERO = 0,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_index,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    addr_nxt, idx_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= addr_nxt;
      out_valid <= valid_nxt;
      out_index <= idx_nxt;
      out_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = rd_addr;
    valid_nxt = out_valid;
    idx_nxt   = out_index;
    data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // Zero entries are dropped without a HOLD cycle; the last address ends the dump.
        if (SKIP_ZERO != 0 && rd_data == '0) begin
          if (rd_addr == LAST) state_nxt = DONE;
          else                 addr_nxt  = rd_addr + AW'(1);
        end else begin
          idx_nxt   = rd_addr;
          data_nxt  = rd_data;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (out_index == LAST) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = rd_addr + AW'(1);
            state_nxt = FETCH;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: full dump, backpressure, skip-zero,
// all-zero, mid-dump reset and start-while-busy.
module tb_regfile_reader;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, start0, start1, ready;
  logic [AW-1:0] a0, a1, i0, i1;
  logic [W-1:0]  d0, d1, od0, od1;
  logic          v0, v1, b0, b1, dn0, dn1;
  logic [W-1:0]  regs [N];

  always #5 clk = ~clk;

  always_comb begin
    d0 = regs[a0];
    d1 = regs[a1];
  end

  regfile_reader #(.NUM_REGS(N), .WIDTH(W), .SKIP_ZERO(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .rd_addr(a0), .rd_data(d0),
    .out_valid(v0), .out_ready(ready), .out_index(i0), .out_data(od0),
    .busy(b0), .done(dn0));

  regfile_reader #(.NUM_REGS(N), .WIDTH(W), .SKIP_ZERO(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .rd_addr(a1), .rd_data(d1),
    .out_valid(v1), .out_ready(ready), .out_index(i1), .out_data(od1),
    .busy(b1), .done(dn1));

  logic          sel;
  logic          sv, sb, sd;
  logic [AW-1:0] si;
  logic [W-1:0]  sdat;

  always_comb begin
    if (sel) begin
      sv = v1; sb = b1; sd = dn1; si = i1; sdat = od1;
    end else begin
      sv = v0; sb = b0; sd = dn0; si = i0; sdat = od0;
    end
  end

  typedef struct {
    logic [W-1:0]  din;
    logic [AW-1:0] eidx;
    logic [W-1:0]  edat;
  } vec_t;

  typedef struct {
    int           ridx;
    logic [W-1:0] val;
  } skip_t;

  vec_t  full_tbl [N];
  skip_t skip_tbl [2];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            stall_cnt;
  logic [AW-1:0] got_idx [$];
  logic [W-1:0]  got_dat [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_dump(input logic s, input int stall_idx, input int stall_len,
                          input int restart_idx, input logic [W-1:0] stall_dat,
                          output int n_done, output int n_busy);
    int post;
    int extra;
    bit restarted;
    got_idx.delete();
    got_dat.delete();
    stall_cnt = 0;
    n_done    = 0;
    n_busy    = 0;
    post      = -1;
    extra     = 0;
    restarted = 0;
    sel       = s;
    ready     = 1'b1;
    @(negedge clk);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    for (int cyc = 0; cyc < 400 && post < 40; cyc++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (post >= 0) begin
        post++;
        if (post == 1) check("busy_after_done", sb, 0);
        else if (sb || sv || sd) extra++;
      end else begin
        if (sd) begin
          n_done++;
          check("done_excl_valid", sv, 0);
          post = 0;
        end else if (sb) begin
          n_busy++;
        end
        if (sv) begin
          if (si == stall_idx && stall_cnt < stall_len) begin
            ready = 1'b0;
            stall_cnt++;
            check("stall_data_held", sdat, stall_dat);
          end else begin
            ready = 1'b1;
            got_idx.push_back(si);
            got_dat.push_back(sdat);
          end
          if (si == restart_idx && !restarted) begin
            restarted = 1;
            if (s) start1 = 1'b1; else start0 = 1'b1;
          end
        end else begin
          ready = 1'b1;
        end
      end
    end
    check("done_seen", (post >= 0), 1);
    check("no_second_dump", extra, 0);
  endtask

  task automatic check_full_seq(input string nm);
    check({nm, "_count"}, got_idx.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < got_idx.size()) begin
        check({nm, "_idx"}, got_idx[i], full_tbl[i].eidx);
        check({nm, "_dat"}, got_dat[i], full_tbl[i].edat);
      end
    end
  endtask

  initial begin
    int nd, nb, hit, dcount;

    for (int i = 0; i < N; i++) begin
      full_tbl[i].din  = W'(i * 3);
      full_tbl[i].eidx = AW'(i);
      full_tbl[i].edat = W'(i * 3);
    end
    skip_tbl[0] = '{2, 88};
    skip_tbl[1] = '{31, 20};

    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    ready  = 1'b1;
    sel    = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = '0;

    #12;
    check("rst_rd_addr", a0, 0);
    check("rst_valid", v0, 0);
    check("rst_index", i0, 0);
    check("rst_data", od0, 0);
    check("rst_busy", b0, 0);
    check("rst_done", dn0, 0);

    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_release0", b0, 0);
    check("idle_after_release1", b1, 0);

    // full dump, no backpressure
    for (int i = 0; i < N; i++) regs[i] = full_tbl[i].din;
    run_dump(1'b0, -1, 0, -1, '0, nd, nb);
    check("full_done_count", nd, 1);
    check_full_seq("full");

    // backpressure on entry 4
    run_dump(1'b0, 4, 5, -1, 32'd12, nd, nb);
    check("bp_stall_cycles", stall_cnt, 5);
    check("bp_done_count", nd, 1);
    check_full_seq("bp");

    // start pulse while entry 7 is held
    run_dump(1'b0, -1, 0, 7, '0, nd, nb);
    check("rebusy_done_count", nd, 1);
    check_full_seq("rebusy");

    // skip zeros: only two nonzero entries
    for (int i = 0; i < N; i++) regs[i] = '0;
    for (int k = 0; k < 2; k++) regs[skip_tbl[k].ridx] = skip_tbl[k].val;
    run_dump(1'b1, -1, 0, -1, '0, nd, nb);
    check("skip_done_count", nd, 1);
    check("skip_count", got_idx.size(), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < got_idx.size()) begin
        check("skip_idx", got_idx[k], skip_tbl[k].ridx);
        check("skip_dat", got_dat[k], skip_tbl[k].val);
      end
    end

    // all zero with skipping: 32 fetch cycles, nothing emitted
    for (int i = 0; i < N; i++) regs[i] = '0;
    run_dump(1'b1, -1, 0, -1, '0, nd, nb);
    check("allzero_done_count", nd, 1);
    check("allzero_count", got_idx.size(), 0);
    check("allzero_fetch_cycles", nb, 32);

    // reset in the middle of entry 10
    for (int i = 0; i < N; i++) regs[i] = full_tbl[i].din;
    sel   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && hit == 0; c++) begin
      @(negedge clk);
      if (v0 && i0 == 5'd10) hit = 1;
    end
    check("reach_entry10", hit, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_rd_addr", a0, 0);
    check("mrst_valid", v0, 0);
    check("mrst_index", i0, 0);
    check("mrst_data", od0, 0);
    check("mrst_busy", b0, 0);
    check("mrst_done", dn0, 0);
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn0) dcount++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dn0 || b0) dcount++;
    end
    check("mrst_no_done_or_busy", dcount, 0);
    run_dump(1'b0, -1, 0, -1, '0, nd, nb);
    check("mrst_restart_first_idx", (got_idx.size() > 0) ? got_idx[0] : 5'd31, 0);
    check_full_seq("mrst_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file entries read per dump (power of two, >= 2).
REQ-002 SHALL have parameter WIDTH, default 32, data width of each entry.
REQ-003 SHALL have parameter SKIP_ZERO, default 0, when 1 entries whose data equals zero are not emitted.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-006 SHALL have port start  input  1  request one full dump of the register file.
REQ-007 SHALL have port rd_addr  output  log2(NUM_REGS)  read address driven to the register file read port.
REQ-008 SHALL have port rd_data  input  WIDTH  combinational read data returned for rd_addr in the same cycle.
REQ-009 SHALL have port out_valid  output  1  out_index/out_data hold a valid entry.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the entry this cycle.
REQ-011 SHALL have port out_index  output  log2(NUM_REGS)  address of the emitted entry.
REQ-012 SHALL have port out_data  output  WIDTH  value of the emitted entry.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a dump completes.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD, DONE.
REQ-016 IDLE: start=1 at a rising edge SHALL set rd_addr=0 and move to FETCH; start=0 SHALL remain in IDLE.
REQ-017 FETCH: at the rising edge SHALL capture rd_addr into out_index and rd_data into out_data, set out_valid=1, move to HOLD.
REQ-018 FETCH with SKIP_ZERO=1 and rd_data=0 SHALL NOT emit the entry: if rd_addr < NUM_REGS-1, increment rd_addr and stay in FETCH; else move to DONE.
REQ-019 HOLD: out_valid=1 and out_ready=1 at a rising edge SHALL complete the transfer; if out_index = NUM_REGS-1 go to DONE with out_valid=0, else increment rd_addr, clear out_valid, go to FETCH.
REQ-020 HOLD with out_ready=0 SHALL keep out_valid, out_index, out_data unchanged.
REQ-021 DONE: SHALL assert done=1 for exactly that cycle and return to IDLE at the next edge.
REQ-022 start while busy=1 SHALL be ignored (no restart, no queued request).
REQ-023 Entries SHALL be emitted in strictly increasing index order, each at most once per dump; minimum 2 cycles per emitted entry.
REQ-024 out_data SHALL be the value present on rd_data during the FETCH cycle; later register-file writes SHALL NOT alter an entry already captured.
REQ-025 rd_addr SHALL never exceed NUM_REGS-1 and SHALL NOT wrap to 0 within a dump.
REQ-026 out_valid SHALL never be asserted outside HOLD; done and out_valid SHALL never be high together.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, rd_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0.
REQ-028 reset=0 mid-dump SHALL abandon the dump with no done pulse; after release a new start SHALL begin again at index 0.
REQ-029 After reset release the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-030 Full dump: regs[i]=i*3, SKIP_ZERO=0, out_ready=1, pulse start -> 32 entries index 0..31 data 0,3,...,93, then one done pulse, busy low next cycle.
REQ-031 Backpressure: out_ready=0 for 5 cycles while entry 4 (data 12) is valid -> out_valid/out_index=4/out_data=12 held stable all 5 cycles, entry 5 follows after acceptance.
REQ-032 Skip zeros: SKIP_ZERO=1, only regs[2]=88 and regs[31]=20 nonzero -> exactly two entries (2,88), (31,20), then done.
REQ-033 All-zero with SKIP_ZERO=1 -> no out_valid, done pulse after 32 FETCH cycles.
REQ-034 Mid-dump reset: assert reset=0 off a clock edge during entry 10 -> all outputs 0 immediately, no done; restart yields index 0 first.
REQ-035 Start while busy: pulse start again during entry 7 -> dump continues unchanged, single done pulse, no second dump.
